uart_mmio: RTL and testbench
============================

# uart_mmio

Parametrised 8N1 UART with TX/RX FIFOs, programmable baud divisor, loopback, sticky error flags and a level interrupt, behind the single-cycle MMIO register bus used throughout the platform. It succeeds the ID-only UART register shell and adds the serial datapath. It sits on the MMIO bus as a peripheral; `uart_tx`/`uart_rx` go to pads.

## Interface
- `FIFO_DEPTH`, 8: entries per TX and RX FIFO; power of two, ≥2.
- `DIV_WIDTH`, 16: width of the baud divisor register, in clk cycles per bit.
- `DIV_RESET`, 16: divisor reset value.
- `ID_VALUE`, 32'hA1C0_0002: value returned at address 0x00.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `addr` in 8: byte register address.
- `wdata` in 32: write data.
- `we` in 1: write strobe, one cycle per access.
- `re` in 1: read strobe, one cycle per access.
- `rdata` out 32: combinational read data, valid in the cycle `re` is high, else 0.
- `ready` out 1: combinational, equals `we | re`; no wait states.
- `uart_tx` out 1: serial out, registered, idle high.
- `uart_rx` in 1: serial in, asynchronous; passes through a 2-flop synchroniser.
- `irq` out 1: level interrupt, registered.

## Operation
- Register map:
  - 0x00 ID (RO) = `ID_VALUE`.
  - 0x04 CTRL (RW), reset 0. Bits: [0] tx_en, [1] rx_en, [2] ie_rx, [3] ie_tx, [4] ie_err, [7] loopback. Bits [5] tx_flush and [6] rx_flush are write-1 pulses and always read 0.
  - 0x08 STATUS (RO except W1C bits). Bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] rx_overrun (sticky, W1C), [6] frame_err (sticky, W1C).
  - 0x0C DIV (RW) [DIV_WIDTH-1:0], reset `DIV_RESET`. Values 0 and 1 behave as 2.
  - 0x10 TXDATA (WO): a write pushes `wdata[7:0]`.
  - 0x14 RXDATA (RO): a read returns the head byte in [7:0] and pops it.
  - Unmapped addresses read 0; writes to RO registers are ignored.
- FIFO rules:
  - A push when full is dropped silently.
  - An RXDATA read when empty returns 0 and does not change the pointers.
  - Full is evaluated at the start of the cycle, so a same-cycle pop does not make room for a push.
  - Flush empties the FIFO in one cycle; a same-cycle push is dropped.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE, or directly to START if the FIFO is non-empty and tx_en=1.
  - Each state holds for one bit time, `DIV` clk cycles.
  - The divisor is latched at START; DIV writes take effect from the next frame.
  - tx_en cleared mid-frame: the current frame completes and no new frame starts.
  - tx_busy = FSM not in IDLE.
- RX FSM: IDLE → START → DATA → STOP.
  - A falling edge on the synchronised line (or internal TX when loopback=1) starts a frame.
  - The line is re-sampled at DIV/2; if high, the start is false and the FSM returns to IDLE.
  - Data and stop bits are sampled every DIV cycles after that point.
  - Stop=1: the byte is pushed. If the RX FIFO is full, the byte is dropped and rx_overrun is set.
  - Stop=0: the byte is dropped, frame_err is set, and the FSM waits for the line to go high before re-arming.
  - rx_en=0 aborts any frame in progress immediately and returns the FSM to IDLE.
- Loopback=1: RX input is the internal TX bit and `uart_tx` is held 1.
- `irq` = (ie_rx & !rx_empty) | (ie_tx & tx_empty) | (ie_err & (rx_overrun | frame_err)), registered.
- W1C on a sticky flag in the same cycle as a new error: set wins.

## Timing
- Reset: `uart_tx`=1, `irq`=0, CTRL=0, DIV=`DIV_RESET`, both FIFOs empty, sticky flags 0, both FSMs IDLE.
- `rdata` and `ready` are combinational and therefore 0 while no strobe is active.
- TXDATA write in cycle N with the FSM idle and tx_en=1: `uart_tx` goes low at the edge ending cycle N+1, so the start bit is first visible in cycle N+2.
- Frame length is exactly 10×DIV cycles. Back-to-back bytes have no idle gap.
- RX: a byte becomes readable (rx_empty=0) 1 cycle after the stop-bit sample. Add 2 cycles of synchroniser delay relative to the pin; loopback bypasses the synchroniser.
- STATUS and `irq` reflect register state after the edge; `irq` lags the flag change by 1 cycle.
- Reset asserted mid-frame: all state clears immediately and `uart_tx` returns to 1 asynchronously.

## Test plan
- Read 0x00 → 32'hA1C0_0002. Read 0x08 after reset → tx_empty=1, rx_empty=1, all other bits 0. Read 0x3C → 0.
- DIV=4, tx_en=1, write 0xA5 → `uart_tx` start bit in cycle N+2, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop; 40 cycles total, tx_busy then clears.
- Loopback=1, rx_en=1, DIV=8, push 0x3C, 0xFF, 0x00 → RXDATA reads return 0x3C, 0xFF, 0x00, then 0 with rx_empty=1. `uart_tx` stays 1 throughout.
- FIFO_DEPTH=8: push 10 bytes with tx_en=0 → tx_full=1 and the last 2 are dropped. Enable TX → exactly 8 frames go out.
- Drive `uart_rx` with stop bit 0 → frame_err=1 and, with ie_err=1, `irq`=1. W1C bit 6 → frame_err=0 and `irq` falls 1 cycle later.
- Receive 9 bytes with no reads → rx_overrun=1 and the 9th byte is lost. Then assert `rst_n` low mid-TX-frame → `uart_tx`=1 and all STATUS bits return to their reset values.

Source files
------------

// File: rtl/uart_mmio.sv
// 8N1 UART peripheral on the single-cycle MMIO bus: TX/RX FIFOs, programmable
// baud divisor, loopback, sticky error flags and a registered level interrupt.

module uart_mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  // Full/empty come from the registered pointers, so a same-cycle pop never frees a slot.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

module uart_mmio #(
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(16),
  parameter logic [31:0]          ID_VALUE   = 32'hA1C0_0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic wr_ctrl, wr_status, wr_div, wr_txdata, rd_rxdata, tx_flush, rx_flush;
  logic tx_en_q, rx_en_q, ie_rx_q, ie_tx_q, ie_err_q, loop_q;
  logic ovr_q, ovr_d, ferr_q, ferr_d, irq_q;
  logic [DIV_WIDTH-1:0] div_q, eff_div;
  logic [7:0] tx_head, rx_head;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;
  logic unused_wdata;

  assign wr_ctrl   = we && (addr == 8'h04);
  assign wr_status = we && (addr == 8'h08);
  assign wr_div    = we && (addr == 8'h0C);
  assign wr_txdata = we && (addr == 8'h10);
  assign rd_rxdata = re && (addr == 8'h14);
  assign tx_flush  = wr_ctrl && wdata[5];
  assign rx_flush  = wr_ctrl && wdata[6];
  assign ready     = we | re;
  assign eff_div   = (div_q < DIV_MIN) ? DIV_MIN : div_q;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {tx_en_q, rx_en_q, ie_rx_q, ie_tx_q, ie_err_q, loop_q} <= '0;
      div_q <= DIV_RESET;
    end else begin
      if (wr_ctrl) {loop_q, ie_err_q, ie_tx_q, ie_rx_q, rx_en_q, tx_en_q} <= {wdata[7], wdata[4:0]};
      if (wr_div)  div_q <= wdata[DIV_WIDTH-1:0];
    end
  end

  // ---------------- TX path ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d, tx_pop, tx_go, tx_start, tx_tick;

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(tx_flush), .push(wr_txdata), .pop(tx_pop),
    .wdata(wdata[7:0]), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign tx_go   = tx_en_q && !tx_empty && !tx_flush;
  assign tx_tick = (tx_cnt_q == tx_div_q);
  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_start   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = CNT_ONE;
        tx_d     = 1'b1;
        tx_start = tx_go;
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = CNT_ONE;
        tx_bit_d   = 3'd0;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_d = CNT_ONE;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
        end
      end
      TX_STOP: if (tx_tick) begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CNT_ONE;
        tx_start   = tx_go;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
    if (tx_start) begin
      tx_state_d = TX_START;
      tx_cnt_d   = CNT_ONE;
      tx_div_d   = eff_div;
      tx_sh_d    = tx_head;
      tx_d       = 1'b0;
      tx_pop     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ONE;
      tx_div_q   <= DIV_MIN;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q | loop_q;

  // ---------------- RX path ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_line, rx_push, rx_ferr, rx_tick;

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(rx_flush), .push(rx_push), .pop(rd_rxdata),
    .wdata(rx_sh_q), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Loopback taps the internal TX bit directly, skipping the synchroniser.
  assign rx_line = loop_q ? tx_q : rx_s2_q;
  assign rx_tick = (rx_cnt_q == rx_div_q);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_ONE;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ONE;
        if (rx_prev_q && !rx_line) begin
          rx_state_d = RX_START;
          rx_div_d   = eff_div;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_cnt_d   = CNT_ONE;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d = CNT_ONE;
        rx_sh_d  = {rx_line, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_d   = CNT_ONE;
        rx_push    = rx_line;
        rx_ferr    = !rx_line;
        rx_state_d = rx_line ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: if (rx_line) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    if (!rx_en_q) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      rx_ferr    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CNT_ONE;
      rx_div_q   <= DIV_MIN;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_line;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- flags, interrupt, read mux ----------------
  assign ovr_d  = (ovr_q  & ~(wr_status & wdata[5])) | (rx_push & rx_full);
  assign ferr_d = (ferr_q & ~(wr_status & wdata[6])) | rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      irq_q  <= (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_empty) | (ie_err_q & (ovr_q | ferr_q));
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (re) begin
      case (addr)
        8'h00: rdata = ID_VALUE;
        8'h04: rdata = {24'd0, loop_q, 2'b00, ie_err_q, ie_tx_q, ie_rx_q, rx_en_q, tx_en_q};
        8'h08: rdata = {25'd0, ferr_q, ovr_q, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
        8'h0C: rdata = 32'(div_q);
        8'h14: rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus checks plus TX-line and RX-read
// scoreboards fed from the stimulus.

module tb_uart_mmio;
  logic        clk, rst_n, we, re, uart_rx;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready, uart_tx, irq;

  uart_mmio dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .ready(ready), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int   tx_frames = 0;
  int   mon_div = 4;
  int   rx_div = 4;
  logic mon_en = 1'b1;
  logic lb_watch = 1'b0;
  logic lb_low_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    $display("wr addr=0x%02h data=0x%08h", a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1 d = rdata;
    $display("rd addr=0x%02h data=0x%08h", a, d);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (rx_div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (rx_div) @(negedge clk);
    end
    uart_rx = stop;
    repeat (rx_div) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * rx_div) @(negedge clk);
    $display("rx pin frame data=0x%02h stop=%0d", b, stop);
  endtask

  // TX line monitor: decodes frames on uart_tx and pops the expected byte.
  initial begin
    logic [7:0] got_b;
    forever begin
      @(negedge uart_tx);
      if (mon_en) begin
        repeat (mon_div / 2) @(negedge clk);
        chk("tx_start", uart_tx, 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (mon_div) @(negedge clk);
          got_b[b] = uart_tx;
        end
        repeat (mon_div) @(negedge clk);
        chk("tx_stop", uart_tx, 1'b1);
        chk("tx_q_nonempty", tx_exp.size() != 0, 1'b1);
        if (tx_exp.size() != 0) chk("tx_byte", got_b, tx_exp.pop_front());
        tx_frames++;
        $display("tx line frame data=0x%02h", got_b);
      end
    end
  end

  always @(negedge clk) if (lb_watch && uart_tx !== 1'b1) lb_low_seen = 1'b1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  frm;
    int f0;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and register map
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_irq", irq, 1'b0);
    addr = 8'h00;
    #1 chk("rdata_idle", rdata, 32'd0);
    chk("ready_idle", ready, 1'b0);
    bus_rd(8'h00, d); chk("id", d, 32'hA1C0_0002);
    bus_rd(8'h08, d); chk("status_rst", d, 32'h0A);
    bus_rd(8'h3C, d); chk("unmapped", d, 32'd0);
    bus_rd(8'h04, d); chk("ctrl_rst", d, 32'd0);
    bus_rd(8'h0C, d); chk("div_rst", d, 32'd16);
    bus_wr(8'h00, 32'h1234_5678);
    bus_rd(8'h00, d); chk("id_ro", d, 32'hA1C0_0002);
    @(negedge clk); addr = 8'h04; re = 1'b1;
    #1 chk("ready_rd", ready, 1'b1);
    @(negedge clk); re = 1'b0;

    // Exact TX timing at DIV=4
    mon_div = 4;
    bus_wr(8'h0C, 32'd4);
    bus_wr(8'h04, 32'h01);
    frm = {1'b1, 8'hA5, 1'b0};
    tx_exp.push_back(8'hA5);
    bus_wr(8'h10, 32'hA5);
    chk("tx_n1_idle", uart_tx, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); re = 1'b0;
      #1 chk("tx_bit", uart_tx, frm[i/4]);
      if (i == 20) begin
        addr = 8'h08; re = 1'b1;
        #1 chk("tx_busy_mid", rdata[4], 1'b1);
      end
    end
    bus_rd(8'h08, d); chk("status_after_tx", d, 32'h0A);

    // Loopback scoreboard
    bus_wr(8'h0C, 32'd8);
    lb_watch = 1'b1;
    bus_wr(8'h04, 32'h83);
    foreach (frm[i]) ;
    rx_exp.push_back(8'h3C); bus_wr(8'h10, 32'h3C);
    rx_exp.push_back(8'hFF); bus_wr(8'h10, 32'hFF);
    rx_exp.push_back(8'h00); bus_wr(8'h10, 32'h00);
    repeat (300) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus_rd(8'h14, d);
      chk("lb_rxdata", d, {24'd0, rx_exp.pop_front()});
    end
    bus_rd(8'h14, d); chk("rx_empty_read", d, 32'd0);
    bus_rd(8'h08, d); chk("lb_rx_empty", d[3], 1'b1);
    lb_watch = 1'b0;
    chk("lb_tx_high", lb_low_seen, 1'b0);

    // TX FIFO overflow then drain
    mon_div = 4;
    bus_wr(8'h0C, 32'd4);
    bus_wr(8'h04, 32'h00);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) tx_exp.push_back(8'h10 + 8'(i));
      bus_wr(8'h10, 32'h10 + i);
    end
    bus_rd(8'h08, d); chk("tx_full", d[1:0], 2'b01);
    f0 = tx_frames;
    bus_wr(8'h04, 32'h01);
    for (int c = 0; c < 600 && tx_exp.size() != 0; c++) @(negedge clk);
    chk("tx_drain", tx_exp.size(), 0);
    repeat (60) @(negedge clk);
    chk("tx_frames", tx_frames - f0, 8);

    // Frame error, irq, W1C
    rx_div = 4;
    bus_wr(8'h04, 32'h12);
    send_rx(8'h5A, 1'b0);
    bus_rd(8'h08, d); chk("status_ferr", d, 32'h4A);
    chk("irq_ferr", irq, 1'b1);
    bus_wr(8'h08, 32'h40);
    chk("irq_lag", irq, 1'b1);
    @(negedge clk);
    chk("irq_clear", irq, 1'b0);
    bus_rd(8'h08, d); chk("status_w1c", d, 32'h0A);

    // RX overrun via the pin
    bus_wr(8'h04, 32'h02);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_exp.push_back(8'hC0 + 8'(i));
      send_rx(8'hC0 + 8'(i), 1'b1);
    end
    bus_rd(8'h08, d); chk("status_ovr", d, 32'h26);
    for (int i = 0; i < 8; i++) begin
      bus_rd(8'h14, d);
      chk("ovr_rxdata", d, {24'd0, rx_exp.pop_front()});
    end
    bus_rd(8'h14, d); chk("ovr_9th_lost", d, 32'd0);
    bus_rd(8'h08, d); chk("status_ovr_sticky", d, 32'h2A);

    // Asynchronous reset in the middle of a TX frame
    mon_en = 1'b0;
    bus_wr(8'h04, 32'h01);
    bus_wr(8'h10, 32'h55);
    @(negedge clk);
    chk("pre_rst_tx", uart_tx, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_tx", uart_tx, 1'b1);
    chk("async_rst_irq", irq, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    bus_rd(8'h08, d); chk("status_post_rst", d, 32'h0A);
    bus_rd(8'h04, d); chk("ctrl_post_rst", d, 32'd0);
    bus_rd(8'h0C, d); chk("div_post_rst", d, 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
